// File: rtl/rx_pkg.sv
// rx_pkg: shared state type and constants for the receive byte sequencer
package rx_pkg;
    typedef enum logic [2:0] {IDLE, HUNT, RECV, DONE, ERR} rx_seq_state_t;
    localparam int BYTE_BITS    = 8;
    localparam int BIT_CNT_W    = $clog2(BYTE_BITS);
    localparam int RX_MAX_BYTES = 255;
endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: bit position within the current byte; byte_done flags the last bit of a byte
module rx_bit_counter
    import rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [BIT_CNT_W-1:0] cnt,
    output logic                 byte_done
);
    assign byte_done = inc & (cnt == BIT_CNT_W'(BYTE_BITS - 1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc)
            cnt <= byte_done ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/rx_byte_sequencer.sv
// rx_byte_sequencer: turns decoded bits after SFD into shift-register strobes and frames the bytes.
// Defining RX_TIMEOUT_EN adds an inter-bit timeout in RECV and the rx_timeout output.
module rx_byte_sequencer
    import rx_pkg::*;
#(
    parameter int MAX_BYTES   = RX_MAX_BYTES,
    parameter int CNT_W       = 8,
    parameter int BIT_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_receive,
    input  logic                 sfd_detected,
    input  logic                 bit_valid,
    input  logic                 bit_value,
    input  logic                 carrier_lost,
    input  logic [BYTE_BITS-1:0] shreg_data,
    output logic                 write_0,
    output logic                 write_1,
    output logic                 shreg_clear,
    output logic [BYTE_BITS-1:0] byte_out,
    output logic                 byte_valid,
    output logic [CNT_W-1:0]     byte_count,
    output logic                 frame_done,
    output logic                 frame_error,
`ifdef RX_TIMEOUT_EN
    output logic                 rx_timeout,
`endif
    output logic                 busy
);
    rx_seq_state_t        state, next_state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 bit_in, byte_done, latch_pending, end_pending;
    logic                 overflow, timeout, capture;

    if (MAX_BYTES < 1 || MAX_BYTES >= (1 << CNT_W) || BIT_TIMEOUT < 1) begin : g_bad_params
        $error("rx_byte_sequencer: CNT_W must hold MAX_BYTES and BIT_TIMEOUT must be positive");
    end

    assign bit_in      = (state == RECV) & bit_valid & ~start_receive;
    assign write_0     = bit_in & ~bit_value;
    assign write_1     = bit_in & bit_value;
    assign overflow    = latch_pending & (byte_count == CNT_W'(MAX_BYTES));
    assign capture     = latch_pending & ~overflow & ~start_receive;
    assign frame_done  = (state == DONE) | (state == ERR);
    assign frame_error = state == ERR;
    assign busy        = (state == HUNT) | (state == RECV);

    rx_bit_counter u_bit_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_receive),
        .inc       (bit_in),
        .cnt       (bit_cnt),
        .byte_done (byte_done)
    );

    // A byte finishing together with carrier loss is completed first (end_pending), then DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start_receive ? HUNT : IDLE;
            HUNT:    next_state = start_receive ? HUNT : sfd_detected ? RECV : HUNT;
            RECV:    next_state = start_receive ? HUNT
                                : (overflow | timeout) ? ERR
                                : end_pending ? (bit_in ? ERR : DONE)
                                : (carrier_lost & ~byte_done)
                                    ? (((bit_cnt == '0) & ~latch_pending & ~bit_in) ? DONE : ERR)
                                : RECV;
            default: next_state = start_receive ? HUNT : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shreg_clear   <= 1'b0;
            latch_pending <= 1'b0;
            end_pending   <= 1'b0;
            byte_valid    <= 1'b0;
            byte_count    <= '0;
            byte_out      <= '0;
        end else begin
            state         <= next_state;
            shreg_clear   <= start_receive;
            latch_pending <= byte_done;
            end_pending   <= byte_done & carrier_lost;
            byte_valid    <= capture;
            if (start_receive)
                byte_count <= '0;
            else if (capture)
                byte_count <= byte_count + 1'b1;
            if (capture)
                byte_out <= shreg_data;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(BIT_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign timeout = (state == RECV) & (tmo_cnt == TMO_W'(BIT_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt    <= '0;
            rx_timeout <= 1'b0;
        end else begin
            tmo_cnt    <= ((state != RECV) | bit_valid) ? '0 : tmo_cnt + 1'b1;
            rx_timeout <= timeout & ~start_receive;
        end
    end
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rx_byte_sequencer.sv
// tb_rx_byte_sequencer: random frames against a frame-level model, scoreboard checked by a forked monitor
module tb_rx_byte_sequencer;
    localparam int MAXB = 3;

    logic       clk = 1'b0, reset = 1'b0;
    logic       start_receive = 1'b0, sfd_detected = 1'b0, bit_valid = 1'b0, bit_value = 1'b0;
    logic       carrier_lost = 1'b0;
    logic [7:0] sreg;
    logic       write_0, write_1, shreg_clear, byte_valid, frame_done, frame_error, busy;
    logic [7:0] byte_out, byte_count;
`ifdef RX_TIMEOUT_EN
    logic       rx_timeout;
`endif

    typedef struct {
        bit         is_frame;
        logic [7:0] data;
        int         cnt;
        bit         err;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0, clr_cnt = 0, hunt_str = 0;
    bit   in_hunt = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // external LSB-first shift register driven by the DUT strobes
    always @(posedge clk or negedge reset)
        if (!reset) sreg <= '0;
        else if (shreg_clear) sreg <= '0;
        else if (write_0 | write_1) sreg <= {write_1, sreg[7:1]};

    rx_byte_sequencer #(.MAX_BYTES(MAXB), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_receive (start_receive),
        .sfd_detected  (sfd_detected),
        .bit_valid     (bit_valid),
        .bit_value     (bit_value),
        .carrier_lost  (carrier_lost),
        .shreg_data    (sreg),
        .write_0       (write_0),
        .write_1       (write_1),
        .shreg_clear   (shreg_clear),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .byte_count    (byte_count),
        .frame_done    (frame_done),
        .frame_error   (frame_error),
`ifdef RX_TIMEOUT_EN
        .rx_timeout    (rx_timeout),
`endif
        .busy          (busy)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push_exp(bit is_frame, logic [7:0] data, int cnt, bit err, int c);
        exp_t e;
        e.is_frame = is_frame;
        e.data     = data;
        e.cnt      = cnt;
        e.err      = err;
        e.cyc      = c;
        q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (write_0 | write_1) chk("strobe_exclusive", write_0 & write_1, 0);
                if (in_hunt && (write_0 || write_1)) hunt_str++;
                if (shreg_clear) clr_cnt++;
                if (byte_valid) begin
                    if (q.size() == 0) chk("spurious_byte_valid", byte_valid, 0);
                    else begin
                        e = q.pop_front();
                        chk("byte_event_kind", e.is_frame, 0);
                        chk("byte_out", byte_out, e.data);
                        chk("byte_count_on_byte", byte_count, e.cnt);
                        chk("byte_valid_cycle", cyc, e.cyc);
                    end
                end
                if (frame_done) begin
                    if (q.size() == 0) chk("spurious_frame_done", frame_done, 0);
                    else begin
                        e = q.pop_front();
                        chk("frame_event_kind", e.is_frame, 1);
                        chk("frame_error", frame_error, e.err);
                        chk("byte_count_on_frame", byte_count, e.cnt);
                    end
                end
            end
        end
    endtask

    // Frame model: every 8 bits make a byte; byte MAXB+1 is an overflow error;
    // a trailing partial byte at carrier loss is an error. abort_bits>=0 leaves the frame mid-RECV.
    task automatic run_frame(input int nb, input int p, input bit simul, input logic [7:0] b0,
                             input int abort_bits);
        logic [7:0] bv [8];
        int  total, done_bytes, clr0, hs0;
        bit  ended, last, cl;
        bv[0] = b0;
        for (int i = 1; i < 8; i++) bv[i] = 8'($urandom);
        total      = abort_bits >= 0 ? abort_bits : nb * 8 + p;
        ended      = 1'b0;
        done_bytes = 0;
        clr0       = clr_cnt;
        hs0        = hunt_str;
        start_receive = 1'b1;
        tick(1);
        start_receive = 1'b0;
        chk("hunt_busy", busy, 1);
        chk("hunt_byte_count_cleared", byte_count, 0);
        in_hunt = 1'b1;
        repeat ($urandom_range(0, 3)) begin
            bit_valid = 1'b1;
            bit_value = 1'($urandom);
            tick(1);
            bit_valid = 1'b0;
            tick(1);
        end
        sfd_detected = 1'b1;
        tick(1);
        sfd_detected = 1'b0;
        in_hunt = 1'b0;
        for (int i = 0; i < total; i++) begin
            last = (i == total - 1) && (abort_bits < 0);
            cl   = simul && last;
            bit_valid    = 1'b1;
            bit_value    = bv[i / 8][i % 8];
            carrier_lost = cl;
            if ((i % 8 == 7) && !ended) begin
                done_bytes++;
                if (done_bytes > MAXB) begin
                    push_exp(1'b1, 8'h00, MAXB, 1'b1, 0);
                    ended = 1'b1;
                end else push_exp(1'b0, bv[i / 8], done_bytes, 1'b0, cyc + 2);
            end
            if (cl && !ended) begin
                push_exp(1'b1, 8'h00, done_bytes, 1'b0, 0);
                ended = 1'b1;
            end
            tick(1);
            bit_valid = 1'b0;
            tick($urandom_range(1, 3));
            carrier_lost = 1'b0;
        end
        if (abort_bits < 0 && !simul) begin
            tick(2);
            carrier_lost = 1'b1;
            if (!ended) push_exp(1'b1, 8'h00, done_bytes, p != 0, 0);
            tick(2);
            carrier_lost = 1'b0;
        end
        if (abort_bits < 0) begin
            tick(4);
            chk("queue_drained", q.size(), 0);
        end
        chk("shreg_clear_once", clr_cnt - clr0, 1);
        chk("hunt_no_strobes", hunt_str - hs0, 0);
    endtask

    initial begin
        int nb, p;
        bit s;
        fork
            monitor();
        join_none
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_shreg_clear", shreg_clear, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_byte_out", byte_out, 0);
        reset = 1'b1;
        tick(2);

        run_frame(1, 0, 1'b0, 8'h4D, -1);
        run_frame(3, 5, 1'b0, 8'($urandom), -1);
        run_frame(4, 0, 1'b0, 8'($urandom), -1);
        run_frame(2, 0, 1'b1, 8'($urandom), -1);
        run_frame(2, 0, 1'b0, 8'($urandom), 12);
        run_frame(1, 0, 1'b0, 8'($urandom), -1);

        run_frame(0, 0, 1'b0, 8'hA5, 11);
        bit_valid = 1'b1;
        bit_value = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_write_1", write_1, 0);
        chk("async_rst_byte_count", byte_count, 0);
        chk("async_rst_byte_out", byte_out, 0);
        chk("async_rst_frame_done", frame_done, 0);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);

        for (int k = 0; k < 40; k++) begin
            nb = $urandom_range(0, 5);
            p  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            s  = (p == 0) && (nb > 0) && ($urandom_range(0, 1) == 1);
            run_frame(nb, p, s, 8'($urandom), -1);
        end

        tick(5);
        chk("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
